// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider with glitch-free divisor staging (applied at period boundaries).
// Optional CLKDIV_DUTY50_EN adds a negedge flop per channel so odd divisors get exact 50% duty.
module multi_clock_divider #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic                    inclk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*WIDTH-1:0] divisor,
  input  logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dact_q, dact_d;
    logic [WIDTH-1:0] dpend_q, dpend_d;
    logic             pvld_q, pvld_d;
    logic             outclk_q, outclk_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] slice;
    logic [WIDTH-1:0] slice_clamp;
    logic             at_end;
    logic             apply;

    assign slice       = divisor[i*WIDTH +: WIDTH];
    assign slice_clamp = (slice < WIDTH'(2)) ? WIDTH'(2) : slice;
    assign at_end      = (cnt_q == dact_q - WIDTH'(1));

    always_ff @(posedge inclk or negedge reset) begin
      if (!reset) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        dact_q   <= WIDTH'(2);
        dpend_q  <= WIDTH'(2);
        pvld_q   <= 1'b0;
        outclk_q <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        dact_q   <= dact_d;
        dpend_q  <= dpend_d;
        pvld_q   <= pvld_d;
        outclk_q <= outclk_d;
        tick_q   <= tick_d;
      end
    end

    // STOPPING keeps counting; the period end decides between a seamless restart and IDLE.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:          if (enable[i]) state_d = RUN;
        RUN, STOPPING: begin
          if (at_end) state_d = enable[i] ? RUN : IDLE;
          else        state_d = enable[i] ? RUN : STOPPING;
        end
        default:       state_d = IDLE;
      endcase
    end

    always_comb begin
      cnt_d   = cnt_q;
      dact_d  = dact_q;
      dpend_d = dpend_q;
      pvld_d  = pvld_q;
      apply   = 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          apply = pvld_q;
        end
        RUN, STOPPING: begin
          if (at_end) begin
            cnt_d = '0;
            apply = pvld_q;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: cnt_d = '0;
      endcase
      // Apply uses the pending flag from before this edge, so a load coinciding with a wrap waits one period.
      if (apply) begin
        dact_d = dpend_q;
        pvld_d = 1'b0;
      end
      if (load[i]) begin
        dpend_d = slice_clamp;
        pvld_d  = 1'b1;
      end
    end

    always_comb begin
      outclk_d = 1'b0;
      tick_d   = 1'b0;
      if (state_d != IDLE) begin
        outclk_d = (cnt_d < (dact_d >> 1));
        tick_d   = (cnt_d == '0);
      end
    end

    assign tick[i] = tick_q;
    assign busy[i] = (state_q != IDLE);

`ifdef CLKDIV_DUTY50_EN
    // Half-cycle stretch of the high phase; only odd divisors need the extra half period.
    logic half_q;
    always_ff @(negedge inclk or negedge reset) begin
      if (!reset) half_q <= 1'b0;
      else        half_q <= outclk_q & dact_q[0];
    end
    assign outclk[i] = outclk_q | half_q;
`else
    assign outclk[i] = outclk_q;
`endif
  end

endmodule
